// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst initiator: one beat per word, streamed write
// data in, read data out, clean abort when a slave stops answering.
module wb_burst_master #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic             wdat_valid_i,
    output logic             wdat_ready_o,
    input  logic [31:0]      wdat_i,
    output logic             rdat_valid_o,
    output logic [31:0]      rdat_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    localparam int unsigned REM_W = LEN_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACTIVE,
        GAP,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               started_q, started_d;
    logic [31:0]        rdat_q, rdat_d;
    logic               rdat_valid_q, rdat_valid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               wdat_ready_q, wdat_ready_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;

    // Low address bits are dropped: the bus is word-addressed.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^cmd_adr_i[1:0];

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rem_d        = rem_q;
        tmo_d        = tmo_q;
        started_d    = started_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d      = cmd_we_i;
                    sel_d     = cmd_sel_i;
                    adr_d     = {cmd_adr_i[31:2], 2'b00};
                    rem_d     = (cmd_len_i == '0) ? (REM_W'(1) << LEN_W)
                                                  : {1'b0, cmd_len_i};
                    tmo_d     = '0;
                    started_d = 1'b0;
                    state_d   = cmd_we_i ? LOAD : ACTIVE;
                end
            end
            LOAD: begin
                if (wdat_valid_i) begin
                    dat_d   = wdat_i;
                    tmo_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (wbm_ack_i) begin
                    started_d = 1'b1;
                    rem_d     = rem_q - REM_W'(1);
                    if (!we_q) begin
                        rdat_d       = wbm_dat_i;
                        rdat_valid_d = 1'b1;
                    end
                    if (rem_q == REM_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        adr_d   = adr_q + 32'd4;
                        state_d = GAP;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                tmo_d   = '0;
                state_d = we_q ? LOAD : ACTIVE;
            end
            FINISH: begin
                we_d    = 1'b0;
                sel_d   = 4'h0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        wdat_ready_d = (state_d == LOAD);
        stb_d        = (state_d == ACTIVE);
        cyc_d        = (state_d == ACTIVE) || (state_d == GAP) ||
                       ((state_d == LOAD) && started_d);
        done_d       = (state_d == FINISH);
    end

    // State and output registers; reset drops the bus cycle at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            adr_q        <= 32'h0;
            dat_q        <= 32'h0;
            rem_q        <= '0;
            tmo_q        <= '0;
            started_q    <= 1'b0;
            rdat_q       <= 32'h0;
            rdat_valid_q <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            wdat_ready_q <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            rem_q        <= rem_d;
            tmo_q        <= tmo_d;
            started_q    <= started_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            err_q        <= err_d;
            done_q       <= done_d;
            cmd_ready_q  <= cmd_ready_d;
            wdat_ready_q <= wdat_ready_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign wdat_ready_o = wdat_ready_q;
    assign rdat_valid_o = rdat_valid_q;
    assign rdat_o       = rdat_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = stb_q;
    assign wbm_we_o     = we_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone classic-cycle initiator that drives the team's SRAM Wishbone slave and other Wishbone slaves on the user bus.
- Accepts single or burst word read/write commands from internal user logic, sequences one Wishbone beat per word, and streams read data back.
- Streams write data in from a valid/ready port.
- Aborts cleanly on slave timeout.

Parameters:
- LEN_W, 8: width of the burst-length field; max burst is 2^LEN_W words.
- TIMEOUT, 16: cycles a strobed beat may wait for ack before abort; must be >= 2.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  async active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write burst, 0=read burst
- cmd_adr_i  in  32  start byte address; bits[1:0] ignored
- cmd_len_i  in  LEN_W  word count; 0 means 2^LEN_W
- cmd_sel_i  in  4  byte lanes, applied to every beat
- wdat_valid_i  in  1  write data offered
- wdat_ready_o  out  1  write word consumed when valid&ready
- wdat_i  in  32  write word
- rdat_valid_o  out  1  one-cycle pulse per read beat
- rdat_o  out  32  read word, valid with rdat_valid_o
- done_o  out  1  one-cycle pulse at burst end
- err_o  out  1  valid with done_o; 1 = timeout abort
- busy_o  out  1  state != IDLE
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte select
- wbm_adr_o  out  32  Wishbone byte address, bits[1:0]=0
- wbm_dat_o  out  32  Wishbone write data
- wbm_ack_i  in  1  Wishbone ack
- wbm_dat_i  in  32  Wishbone read data

Behaviour:
- Reset (wb_rst_i, asynchronous, active-high; clock wb_clk_i):
  - all outputs 0 except cmd_ready_o=1; state=IDLE.
  - Asserting reset mid-burst drops cyc/stb immediately; no done_o pulse is emitted.
- States: IDLE, LOAD, ACTIVE, GAP, FINISH.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch we, sel, {adr[31:2],2'b00}, and remaining = len (0 maps to 2^LEN_W, counter width LEN_W+1).
  - Go to LOAD if write, else ACTIVE.
  - cmd_ready_o=0 in all other states.
- LOAD (write only):
  - cyc=1 (after first beat) / 0 (before first beat); stb=0.
  - wdat_ready_o=1; on wdat_valid_i, latch wdat_i into wbm_dat_o and go to ACTIVE.
  - No timeout while waiting on write data.
- ACTIVE:
  - cyc=stb=1; we/sel/adr/dat held stable.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - On wbm_ack_i:
    - read: rdat_o<=wbm_dat_i and rdat_valid_o pulses the next cycle.
    - remaining-=1.
    - If remaining becomes 0, go to FINISH with err=0.
    - Otherwise adr+=4 (wraps mod 2^32) and go to GAP.
  - If the counter reaches TIMEOUT-1 with no ack: go to FINISH with err=1, drop cyc/stb, discard remaining beats.
  - Ack in the same cycle as timeout expiry counts as ack (ack wins).
- GAP:
  - cyc=1, stb=0 for exactly one cycle; this guarantees the slave's ack register returns to 0.
  - Next state: LOAD for writes, ACTIVE for reads.
- FINISH:
  - cyc=stb=0; done_o=1 and err_o valid for one cycle; then IDLE.
  - err_o is 0 whenever done_o=0.
- wbm_cyc_o stays high from the first strobe through the last ack, including LOAD between beats.
- wbm_ack_i seen in IDLE, GAP, LOAD or FINISH is ignored and changes no state.
- wbm_we_o and wbm_sel_o are 0 in IDLE.
- Beat latency: a read beat to a zero-wait slave is 2 cycles strobe-to-ack plus 1 GAP cycle, i.e. 3 cycles/word.

Test Plan:
1. Single read: cmd adr=0x0000_0010, len=1, sel=0xF, slave returns 0xDEADBEEF -> wbm_adr_o=0x10, stb high until ack, rdat_valid_o pulse with rdat_o=0xDEADBEEF, done_o=1, err_o=0, cyc low after.
2. 4-word write burst: adr=0x100, wdat 0x11,0x22,0x33,0x44 with 2-cycle gaps on wdat_valid_i -> four beats at 0x100/0x104/0x108/0x10C carrying those words; stb=0 between beats; cyc continuous; one done_o.
3. Read-back through the SRAM slave of scenario 2: sel=0x3 -> rdat_o values 0x11, 0x22, 0x33, 0x44 (upper lanes zero); exactly 4 rdat_valid_o pulses.
4. Timeout: slave never acks, TIMEOUT=16 -> stb high for exactly 16 cycles, then cyc=stb=0, done_o=1 with err_o=1, no rdat_valid_o.
5. Ack on the final timeout cycle -> beat completes normally, err_o=0.
6. Boundary and reset:
   - len=0 with LEN_W=2 -> exactly 4 beats.
   - adr=0xFFFF_FFFC, len=2 -> second beat at 0x0000_0000.
   - wb_rst_i pulsed during ACTIVE -> cyc/stb low asynchronously, cmd_ready_o=1, no done_o.
